// File: rtl/pulse_seq_pkg.sv
// Shared types and field offsets for the pulse envelope sequencer.
package pulse_seq_pkg;

  localparam int ENV_WIDTH_DEF      = 24;
  localparam int ENV_ADDR_WIDTH_DEF = 12;
  localparam int PHASE_WIDTH_DEF    = 17;
  localparam int FREQ_WIDTH_DEF     = 9;
  localparam int AMP_WIDTH_DEF      = 16;
  localparam int CFG_WIDTH_DEF      = 4;
  localparam int MEM_LATENCY_DEF    = 2;

  // env_word layout: start address in the low bits, sample count above it
  localparam int ENV_START_LSB = 0;
  localparam int ENV_LEN_LSB   = ENV_START_LSB + ENV_ADDR_WIDTH_DEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [PHASE_WIDTH_DEF-1:0] phase;
    logic [FREQ_WIDTH_DEF-1:0]  freq;
    logic [AMP_WIDTH_DEF-1:0]   amp;
    logic [CFG_WIDTH_DEF-1:0]   cfg;
  } pulse_params_t;

endpackage

// File: rtl/pulse_env_sequencer_if.sv
// Pulse-register command side and envelope-memory/DSP side of the sequencer.
interface pulse_env_sequencer_if
  import pulse_seq_pkg::*;
#(
  parameter int ENV_WIDTH      = ENV_WIDTH_DEF,
  parameter int ENV_ADDR_WIDTH = ENV_ADDR_WIDTH_DEF,
  parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
  parameter int FREQ_WIDTH     = FREQ_WIDTH_DEF,
  parameter int AMP_WIDTH      = AMP_WIDTH_DEF,
  parameter int CFG_WIDTH      = CFG_WIDTH_DEF
) ();

  logic [ENV_WIDTH-1:0]      env_word;
  logic [PHASE_WIDTH-1:0]    phase;
  logic [FREQ_WIDTH-1:0]     freq;
  logic [AMP_WIDTH-1:0]      amp;
  logic [CFG_WIDTH-1:0]      cfg;
  logic                      cstrobe_in;

  logic [ENV_ADDR_WIDTH-1:0] env_addr;
  logic                      env_rd_en;
  logic                      env_valid_out;
  logic [PHASE_WIDTH-1:0]    phase_out;
  logic [FREQ_WIDTH-1:0]     freq_out;
  logic [AMP_WIDTH-1:0]      amp_out;
  logic [CFG_WIDTH-1:0]      cfg_out;
  logic                      busy;
  logic                      done;

  modport master (
    output env_word, phase, freq, amp, cfg, cstrobe_in,
    input  env_addr, env_rd_en, env_valid_out, phase_out, freq_out,
           amp_out, cfg_out, busy, done
  );

  modport slave (
    input  env_word, phase, freq, amp, cfg, cstrobe_in,
    output env_addr, env_rd_en, env_valid_out, phase_out, freq_out,
           amp_out, cfg_out, busy, done
  );

endinterface

// File: rtl/pulse_env_sequencer_pipe_delay.sv
// Reset-clearable shift-register delay line, DEPTH register stages deep.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pulse_env_sequencer.sv
// Turns each command strobe into a run of envelope read addresses and delays
// the pulse parameters so they meet the envelope samples at the DSP stage.
module pulse_env_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int ENV_WIDTH      = ENV_WIDTH_DEF,
  parameter int ENV_ADDR_WIDTH = ENV_ADDR_WIDTH_DEF,
  parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
  parameter int FREQ_WIDTH     = FREQ_WIDTH_DEF,
  parameter int AMP_WIDTH      = AMP_WIDTH_DEF,
  parameter int CFG_WIDTH      = CFG_WIDTH_DEF,
  parameter int MEM_LATENCY    = MEM_LATENCY_DEF
) (
  input logic                 clk,
  input logic                 reset,
  pulse_env_sequencer_if.slave bus
);

  localparam int LEN_WIDTH = ENV_WIDTH - ENV_ADDR_WIDTH;
  localparam int PIPE_W    = 1 + $bits(pulse_params_t);

  seq_state_t                state_q, state_d;
  logic [ENV_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      remain_q, remain_d;
  logic                      rdEn_q, rdEn_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  pulse_params_t             params_q, params_d;

  logic [ENV_ADDR_WIDTH-1:0] newStart;
  logic [LEN_WIDTH-1:0]      newLen;

  logic [PIPE_W-1:0]         pipeOut;
  logic                      pipeValid;
  pulse_params_t             pipeParams;
  logic                      validOut_q;
  pulse_params_t             paramsOut_q;

  assign newStart = bus.env_word[ENV_START_LSB +: ENV_ADDR_WIDTH];
  assign newLen   = bus.env_word[ENV_WIDTH-1:ENV_ADDR_WIDTH];

  // A strobe always wins: it restarts the sequence whether idle or mid-pulse.
  // remain counts samples still to issue after the current address.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    rdEn_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    params_d = params_q;

    if (bus.cstrobe_in) begin
      params_d.phase = bus.phase;
      params_d.freq  = bus.freq;
      params_d.amp   = bus.amp;
      params_d.cfg   = bus.cfg;
      if (newLen != '0) begin
        state_d  = RUN;
        addr_d   = newStart;
        remain_d = newLen - LEN_WIDTH'(1);
        rdEn_d   = 1'b1;
        busy_d   = 1'b1;
        done_d   = (newLen == LEN_WIDTH'(1));
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (remain_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d   = addr_q + ENV_ADDR_WIDTH'(1);
            remain_d = remain_q - LEN_WIDTH'(1);
            rdEn_d   = 1'b1;
            busy_d   = 1'b1;
            done_d   = (remain_q == LEN_WIDTH'(1));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      rdEn_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      params_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      rdEn_q   <= rdEn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      params_q <= params_d;
    end
  end

  // Tapping next-state values lets the output register below land exactly
  // MEM_LATENCY cycles after the matching env_rd_en cycle.
  pipe_delay #(
    .WIDTH (PIPE_W),
    .DEPTH (MEM_LATENCY)
  ) u_align (
    .clk    (clk),
    .reset  (reset),
    .data_i ({rdEn_d, params_d}),
    .data_o (pipeOut)
  );

  assign pipeValid  = pipeOut[PIPE_W-1];
  assign pipeParams = pipeOut[PIPE_W-2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      validOut_q  <= 1'b0;
      paramsOut_q <= '0;
    end else begin
      validOut_q <= pipeValid;
      if (pipeValid) paramsOut_q <= pipeParams;
    end
  end

  assign bus.env_addr      = addr_q;
  assign bus.env_rd_en     = rdEn_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.env_valid_out = validOut_q;
  assign bus.phase_out     = paramsOut_q.phase;
  assign bus.freq_out      = paramsOut_q.freq;
  assign bus.amp_out       = paramsOut_q.amp;
  assign bus.cfg_out       = paramsOut_q.cfg;

endmodule

// File: tb/tb_pulse_env_sequencer.sv
// Scoreboard bench for pulse_env_sequencer: expected addresses, done pulses and
// aligned samples are queued per cycle at each strobe and retired by a monitor.
module tb_pulse_env_sequencer;

  localparam int ENV_WIDTH      = 24;
  localparam int ENV_ADDR_WIDTH = 12;
  localparam int PHASE_WIDTH    = 17;
  localparam int FREQ_WIDTH     = 9;
  localparam int AMP_WIDTH      = 16;
  localparam int CFG_WIDTH      = 4;
  localparam int ML             = 2;
  localparam int PW = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + CFG_WIDTH;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
  } rdExp_t;

  typedef struct {
    int            cyc;
    logic [PW-1:0] params;
  } validExp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   enMon = 1'b0;

  rdExp_t        rdQ[$];
  int            doneQ[$];
  validExp_t     validQ[$];
  logic [PW-1:0] lastOut = '0;

  int numCompared = 0;
  int numMismatched = 0;

  pulse_env_sequencer_if #(
    .ENV_WIDTH(ENV_WIDTH), .ENV_ADDR_WIDTH(ENV_ADDR_WIDTH), .PHASE_WIDTH(PHASE_WIDTH),
    .FREQ_WIDTH(FREQ_WIDTH), .AMP_WIDTH(AMP_WIDTH), .CFG_WIDTH(CFG_WIDTH)
  ) bus ();

  pulse_env_sequencer #(
    .ENV_WIDTH(ENV_WIDTH), .ENV_ADDR_WIDTH(ENV_ADDR_WIDTH), .PHASE_WIDTH(PHASE_WIDTH),
    .FREQ_WIDTH(FREQ_WIDTH), .AMP_WIDTH(AMP_WIDTH), .CFG_WIDTH(CFG_WIDTH),
    .MEM_LATENCY(ML)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic prune(input int rdLimit, input int doneLimit, input int validLimit);
    while (rdQ.size() > 0 && rdQ[$].cyc > rdLimit) void'(rdQ.pop_back());
    while (doneQ.size() > 0 && doneQ[$] > doneLimit) void'(doneQ.pop_back());
    while (validQ.size() > 0 && validQ[$].cyc > validLimit) void'(validQ.pop_back());
  endtask

  // Drives a one-cycle strobe in the current cycle and queues its expected results.
  task automatic applyStimulus(input logic [11:0] start, input logic [11:0] len,
                               input logic [16:0] ph, input logic [8:0] fr,
                               input logic [15:0] am, input logic [3:0] cf);
    int t;
    logic [PW-1:0] p;
    t = cyc;
    p = {ph, fr, am, cf};
    bus.env_word   = {len, start};
    bus.phase      = ph;
    bus.freq       = fr;
    bus.amp        = am;
    bus.cfg        = cf;
    bus.cstrobe_in = 1'b1;
    prune(t, t, t + ML);
    if (len == 12'd0) begin
      doneQ.push_back(t + 1);
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        rdQ.push_back('{t + 1 + k, start + 12'(k)});
        validQ.push_back('{t + 1 + ML + k, p});
      end
      doneQ.push_back(t + int'(len));
    end
    step(1);
    bus.cstrobe_in = 1'b0;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_addr"},  64'(bus.env_addr), 64'd0);
    checkOutput({pfx, "_rd_en"}, 64'(bus.env_rd_en), 64'd0);
    checkOutput({pfx, "_busy"},  64'(bus.busy), 64'd0);
    checkOutput({pfx, "_done"},  64'(bus.done), 64'd0);
    checkOutput({pfx, "_valid"}, 64'(bus.env_valid_out), 64'd0);
    checkOutput({pfx, "_outs"},  64'({bus.phase_out, bus.freq_out, bus.amp_out, bus.cfg_out}), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic expRd, expDone, expValid;
    logic [PW-1:0] obsParams;
    if (enMon) begin
      expRd    = (rdQ.size() > 0) && (rdQ[0].cyc == cyc);
      expDone  = (doneQ.size() > 0) && (doneQ[0] == cyc);
      expValid = (validQ.size() > 0) && (validQ[0].cyc == cyc);
      obsParams = {bus.phase_out, bus.freq_out, bus.amp_out, bus.cfg_out};

      checkOutput("rd_en", 64'(bus.env_rd_en), 64'(expRd));
      checkOutput("busy", 64'(bus.busy), 64'(expRd));
      if (expRd) begin
        checkOutput("addr", 64'(bus.env_addr), 64'(rdQ[0].addr));
        void'(rdQ.pop_front());
      end

      checkOutput("done", 64'(bus.done), 64'(expDone));
      if (expDone) void'(doneQ.pop_front());

      checkOutput("valid", 64'(bus.env_valid_out), 64'(expValid));
      if (expValid) begin
        checkOutput("aligned_params", 64'(obsParams), 64'(validQ[0].params));
        lastOut = validQ[0].params;
        void'(validQ.pop_front());
      end else begin
        checkOutput("held_params", 64'(obsParams), 64'(lastOut));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.env_word   = '0;
    bus.phase      = '0;
    bus.freq       = '0;
    bus.amp        = '0;
    bus.cfg        = '0;
    bus.cstrobe_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    checkResetState("rst");
    enMon = 1'b1;
    step(2);

    $display("[TB] single pulse");
    applyStimulus(12'h010, 12'd4, 17'h1ABCD, 9'h155, 16'hBEEF, 4'h5);
    step(8);

    $display("[TB] address wrap");
    applyStimulus(12'hFFE, 12'd4, 17'h00123, 9'h0AA, 16'h7777, 4'hA);
    step(8);

    $display("[TB] preemption");
    applyStimulus(12'h100, 12'd8, 17'h0F0F0, 9'h011, 16'h4321, 4'h1);
    step(2);
    applyStimulus(12'h200, 12'd2, 17'h10001, 9'h022, 16'h1234, 4'h2);
    step(10);

    $display("[TB] back to back");
    applyStimulus(12'h300, 12'd3, 17'h00003, 9'h033, 16'hAAAA, 4'h3);
    step(2);
    applyStimulus(12'h400, 12'd2, 17'h00004, 9'h044, 16'h5555, 4'h4);
    step(10);

    $display("[TB] zero length");
    applyStimulus(12'h777, 12'd0, 17'h1FFFF, 9'h1FF, 16'hDEAD, 4'hF);
    step(6);

    $display("[TB] single sample");
    applyStimulus(12'h0FF, 12'd1, 17'h0ABCD, 9'h101, 16'h0F0F, 4'h6);
    step(6);

    $display("[TB] reset mid pulse");
    applyStimulus(12'h500, 12'd6, 17'h05555, 9'h055, 16'hC0DE, 4'h7);
    step(1);
    reset = 1'b1;
    prune(cyc, cyc, cyc);
    lastOut = '0;
    step(1);
    bus.env_word   = {12'd3, 12'h050};
    bus.cstrobe_in = 1'b1;
    step(1);
    bus.cstrobe_in = 1'b0;
    reset = 1'b0;
    checkResetState("rst2");
    step(3);
    applyStimulus(12'h020, 12'd3, 17'h0CAFE, 9'h066, 16'h9876, 4'h8);
    step(8);

    $display("[TB] random strobes");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(12'($urandom), 12'($urandom_range(0, 5)), 17'($urandom),
                    9'($urandom), 16'($urandom), 4'($urandom));
      step(int'($urandom_range(0, 6)));
    end
    step(20);

    checkOutput("drain_rd", 64'(rdQ.size()), 64'd0);
    checkOutput("drain_done", 64'(doneQ.size()), 64'd0);
    checkOutput("drain_valid", 64'(validQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
